// File: rtl/esfa_bench_pkg.sv
// Shared types and default sizing for the ESFA benchmark driver.
package esfa_bench_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_NUM_RUNS    = 16;
  localparam int unsigned DEF_ACK_TIMEOUT = 256;
  localparam int unsigned DEF_RUN_TIMEOUT = 65536;
  localparam int unsigned DEF_GAP_CYCLES  = 4;
  localparam int unsigned DEF_CYC_W       = 32;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/esfa_sat_counter.sv
// Saturating counter: clear, increment and add in one cycle.
// clear together with inc loads 1; the result sticks at all-ones instead of wrapping.
module esfa_sat_counter
  import esfa_bench_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic         add,
  input  logic [W-1:0] add_val,
  output logic [W-1:0] count
);

  logic [W-1:0] base;
  logic [W-1:0] addend;
  logic [W:0]   sum;
  logic [W-1:0] count_next;

  // Next value: clear first, then add operands with a carry bit for saturation
  always_comb begin
    base       = clear ? '0 : count;
    addend     = add ? add_val : '0;
    sum        = {1'b0, base} + {1'b0, addend} + {{W{1'b0}}, inc};
    count_next = sum[W] ? '1 : sum[W-1:0];
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end

endmodule

// File: rtl/esfa_benchmark_driver.sv
// ESFA benchmark run initiator: issues NUM_RUNS runs over the
// doRun/isRunning/wasSuccessful handshake, times each run and tallies results.
module esfa_benchmark_driver
  import esfa_bench_pkg::*;
#(
  parameter int unsigned NUM_RUNS    = DEF_NUM_RUNS,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int unsigned RUN_TIMEOUT = DEF_RUN_TIMEOUT,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned CYC_W       = DEF_CYC_W,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             doRun,
  input  logic             isRunning,
  input  logic             wasSuccessful,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] passCount,
  output logic [CNT_W-1:0] failCount,
  output logic [CYC_W-1:0] lastCycles,
  output logic [CYC_W-1:0] totalCycles
);

  localparam int unsigned IDX_W = $clog2(NUM_RUNS + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CYC_W-1:0] ACK_LAST  = CYC_W'(ACK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] RUN_LIMIT = CYC_W'(RUN_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RUNS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_t           state, next_state;
  logic             armed;
  logic [IDX_W-1:0] run_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [CYC_W-1:0] ack_cnt;
  logic [CYC_W-1:0] run_cnt;
  logic             start_campaign, ack, complete, timeout;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state, handshake outputs and per-cycle event strobes
  always_comb begin
    next_state     = state;
    start_campaign = 1'b0;
    ack            = 1'b0;
    complete       = 1'b0;
    timeout        = 1'b0;
    doRun          = (state == ST_ISSUE);
    busy           = (state == ST_ISSUE) || (state == ST_RUN) || (state == ST_GAP);
    done           = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_campaign = 1'b1;
          next_state     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (isRunning) begin
          ack        = 1'b1;
          next_state = ST_RUN;
        end else if (ack_cnt == ACK_LAST) begin
          timeout    = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_RUN: begin
        // Release is checked before the limit so a tie counts as a completed run
        if (!isRunning) begin
          complete   = 1'b1;
          next_state = (run_idx == IDX_LAST) ? ST_DONE : ST_GAP;
        end else if (run_cnt == RUN_LIMIT) begin
          timeout    = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_GAP: begin
        if (!isRunning && gap_cnt == GAP_LAST) next_state = ST_ISSUE;
      end
      ST_DONE: begin
        if (start && armed) begin
          start_campaign = 1'b1;
          next_state     = ST_ISSUE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Campaign bookkeeping: error flag, restart qualifier, run index, gap count, last run
  always_ff @(posedge clk) begin
    if (reset) begin
      error      <= 1'b0;
      armed      <= 1'b0;
      run_idx    <= '0;
      gap_cnt    <= '0;
      lastCycles <= '0;
    end else begin
      armed   <= (state == ST_DONE) && (armed || !start);
      gap_cnt <= (state == ST_GAP && !isRunning) ? gap_cnt + 1'b1 : '0;
      if (start_campaign) begin
        error      <= 1'b0;
        run_idx    <= '0;
        lastCycles <= '0;
      end else begin
        if (timeout) error <= 1'b1;
        if (complete) begin
          run_idx    <= run_idx + 1'b1;
          lastCycles <= run_cnt;
        end
      end
    end
  end

  esfa_sat_counter #(.W(CNT_W)) u_pass (
    .clk(clk), .reset(reset), .clear(start_campaign),
    .inc(complete && wasSuccessful), .add(1'b0), .add_val('0), .count(passCount)
  );

  esfa_sat_counter #(.W(CNT_W)) u_fail (
    .clk(clk), .reset(reset), .clear(start_campaign),
    .inc(complete && !wasSuccessful), .add(1'b0), .add_val('0), .count(failCount)
  );

  // Held at zero outside ISSUE so every issue window starts fresh
  esfa_sat_counter #(.W(CYC_W)) u_ack_timer (
    .clk(clk), .reset(reset), .clear(state != ST_ISSUE),
    .inc(state == ST_ISSUE), .add(1'b0), .add_val('0), .count(ack_cnt)
  );

  // Loads 1 on the acknowledge cycle, then counts busy cycles
  esfa_sat_counter #(.W(CYC_W)) u_run_timer (
    .clk(clk), .reset(reset), .clear(ack),
    .inc(ack || (state == ST_RUN && isRunning)), .add(1'b0), .add_val('0), .count(run_cnt)
  );

  esfa_sat_counter #(.W(CYC_W)) u_total (
    .clk(clk), .reset(reset), .clear(start_campaign),
    .inc(1'b0), .add(complete), .add_val(run_cnt), .count(totalCycles)
  );

endmodule

// File: doc/esfa_benchmark_driver.md
Name: esfa_benchmark_driver

Overview:
- Hardware initiator for the ESFA benchmark run handshake (doRun / isRunning / wasSuccessful), so that campaigns run on the FPGA with no testbench stimulus.
- Issues NUM_RUNS back-to-back benchmark runs to the benchmark design, measures cycles per run, and tallies pass/fail.
- Sits between the board-level start control (button or debug register) and the benchmark design. Its results feed LEDs or a debug readout.

Parameters:
- NUM_RUNS, 16, runs per campaign (≥1).
- ACK_TIMEOUT, 256, max cycles from doRun rising to isRunning high.
- RUN_TIMEOUT, 65536, max cycles isRunning may stay high per run.
- GAP_CYCLES, 4, idle cycles between runs (≥1).
- CYC_W, 32, cycle-counter width.
- CNT_W, 16, pass/fail counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  campaign request; level, sampled in IDLE/DONE only
- doRun  out  1  run request to the benchmark design
- isRunning  in  1  benchmark busy acknowledge
- wasSuccessful  in  1  benchmark result; valid on the cycle isRunning is first seen low after a run
- busy  out  1  campaign in progress
- done  out  1  campaign finished; held until the next start
- error  out  1  campaign aborted on timeout; held until the next start
- passCount  out  CNT_W  successful runs
- failCount  out  CNT_W  unsuccessful runs
- lastCycles  out  CYC_W  cycles of the most recent run
- totalCycles  out  CYC_W  summed cycles of all completed runs

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-campaign aborts immediately with no completion pulse, and doRun is low the cycle after reset.
- States: IDLE, ISSUE, RUN, GAP, DONE.
- IDLE:
  - start=1 → ISSUE.
  - On this transition: clear counters, done and error; set busy=1; runIdx=0.
- ISSUE:
  - doRun=1; ack timer increments.
  - isRunning=1 → RUN; doRun drops the next cycle; run timer loads 1.
  - Ack timer reaches ACK_TIMEOUT → DONE with error=1, doRun=0.
- RUN:
  - doRun=0; run timer increments each cycle isRunning=1.
  - isRunning=0 → sample wasSuccessful that cycle:
    - pass → passCount+1; fail → failCount+1.
    - lastCycles = run timer.
    - totalCycles += run timer.
    - runIdx+1.
    - If runIdx+1 == NUM_RUNS → DONE, else → GAP.
  - Run timer reaches RUN_TIMEOUT → DONE with error=1. The timed-out run is not counted.
- GAP:
  - Count GAP_CYCLES cycles with isRunning=0, then → ISSUE.
  - If isRunning=1 during GAP, the gap count restarts (waits for the benchmark to settle).
- DONE:
  - busy=0; done=1.
  - start must be seen low, then high, to begin a new campaign. This edge qualification prevents an immediate re-run while start is held.
- Arithmetic:
  - CNT_W and CYC_W counters saturate at all-ones; no wrap.
  - totalCycles addition saturates.
  - The run timer counts from ack to the release cycle inclusive of the first cycle.
- Simultaneous events:
  - isRunning falling on the same cycle the run timer hits RUN_TIMEOUT counts as completed, not an error.
  - isRunning already high while in IDLE: ISSUE is accepted immediately.
- Invariant: passCount + failCount == completed runs ≤ NUM_RUNS.

Decomposition:
- Shared package esfa_bench_pkg holds:
  - state encoding typedef (IDLE..DONE);
  - default widths and timeout constants.
- One sub-module, esfa_sat_counter (parameterized width; inc/add/clear; saturating), is instantiated for:
  - passCount and failCount;
  - the ack timer and run timer;
  - totalCycles.

Test Plan:
- Bench uses a behavioural responder: raises isRunning 2 cycles after doRun, holds it for L cycles, drives wasSuccessful.
- Nominal: NUM_RUNS=4, L=10, all pass → passCount=4, failCount=0, lastCycles=10, totalCycles=40, done=1, error=0.
- Mixed results: runs pass,fail,pass,fail → passCount=2, failCount=2. Between runs, doRun stays low ≥ GAP_CYCLES=4 cycles.
- Ack timeout: responder never raises isRunning → error=1, done=1 after ACK_TIMEOUT=256 cycles, counters 0, doRun low thereafter.
- Run timeout: RUN_TIMEOUT=100, L=200 → error=1 at cycle 100 of the run, failCount unchanged. Also check the completion/timeout tie case, which must count as completed.
- Reset mid-RUN: assert reset during run 2 → next cycle all outputs 0, state IDLE. A new start succeeds normally.
- Held start: keep start=1 through DONE → no second campaign until start drops and rises. Saturation check: CNT_W=2, NUM_RUNS=5 all pass → passCount=3.
